// File: rtl/usb_pad_bridge.sv
// Multi-port USB pad bridge: registered drive, synchronised and deglitched receive,
// transmit echo with turnaround guard, and long-SE0 bus-reset detection per port.
module usb_pad_bridge #(
    parameter int NUM_PORTS        = 2,
    parameter int SYNC_STAGES      = 2,
    parameter int FILT_LEN         = 3,
    parameter int GUARD_CYCLES     = 4,
    parameter int SE0_RESET_CYCLES = 250
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_PORTS-1:0]   core_dp_o,
    input  logic [NUM_PORTS-1:0]   core_dm_o,
    input  logic [NUM_PORTS-1:0]   core_oe,
    output logic [NUM_PORTS-1:0]   core_dp_i,
    output logic [NUM_PORTS-1:0]   core_dm_i,
    output logic [NUM_PORTS-1:0]   pad_dp_o,
    output logic [NUM_PORTS-1:0]   pad_dm_o,
    output logic [NUM_PORTS-1:0]   pad_oe,
    input  logic [NUM_PORTS-1:0]   pad_dp_i,
    input  logic [NUM_PORTS-1:0]   pad_dm_i,
    output logic [2*NUM_PORTS-1:0] line_state,
    output logic [NUM_PORTS-1:0]   bus_reset
);

    localparam int CNT_W = $clog2(FILT_LEN + 1);
    // A zero-cycle guard still needs a one-bit counter that simply never leaves 0.
    localparam int GRD_W = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
    localparam int RST_W = $clog2(SE0_RESET_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILT_LEN - 1);
    localparam logic [GRD_W-1:0] GRD_LOAD = GRD_W'(GUARD_CYCLES);
    localparam logic [RST_W-1:0] RST_MAX  = RST_W'(SE0_RESET_CYCLES);

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic                   oe_q;
        logic                   dp_q;
        logic                   dm_q;
        logic [SYNC_STAGES-1:0] sync_dp;
        logic [SYNC_STAGES-1:0] sync_dm;
        logic [1:0]             s;
        logic [1:0]             f;
        logic [CNT_W-1:0]       cnt;
        logic [GRD_W-1:0]       g;
        logic                   echo;
        logic [RST_W-1:0]       r;
        logic [RST_W-1:0]       r_next;
        logic                   br_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                oe_q <= 1'b0;
                dp_q <= 1'b0;
                dm_q <= 1'b0;
            end else begin
                oe_q <= core_oe[p];
                dp_q <= core_dp_o[p];
                dm_q <= core_dm_o[p];
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync_dp <= '0;
                sync_dm <= '0;
            end else begin
                sync_dp <= {sync_dp[SYNC_STAGES-2:0], pad_dp_i[p]};
                sync_dm <= {sync_dm[SYNC_STAGES-2:0], pad_dm_i[p]};
            end
        end

        assign s = {sync_dp[SYNC_STAGES-1], sync_dm[SYNC_STAGES-1]};

        // Accept a new pair only after it has differed from f for FILT_LEN cycles in a row.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                f   <= 2'b00;
                cnt <= '0;
            end else if (s == f) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                f   <= s;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                g <= '0;
            end else if (oe_q) begin
                g <= GRD_LOAD;
            end else if (g != '0) begin
                g <= g - GRD_W'(1);
            end
        end

        assign echo = oe_q | (g != '0);

        // SE0 only counts toward a bus reset while we are not hearing our own drive.
        always_comb begin
            r_next = '0;
            if ((f == 2'b00) && !echo) begin
                r_next = (r == RST_MAX) ? r : r + RST_W'(1);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r    <= '0;
                br_q <= 1'b0;
            end else begin
                r    <= r_next;
                br_q <= (r_next == RST_MAX);
            end
        end

        assign pad_oe[p]             = oe_q;
        assign pad_dp_o[p]           = dp_q;
        assign pad_dm_o[p]           = dm_q;
        assign core_dp_i[p]          = echo ? dp_q : f[1];
        assign core_dm_i[p]          = echo ? dm_q : f[0];
        assign line_state[2*p+1:2*p] = f;
        assign bus_reset[p]          = br_q;
    end

endmodule

// File: tb/tb_usb_pad_bridge.sv
// Randomised bench for usb_pad_bridge: every output is compared each cycle against
// a history-based model of the drive, filter, guard and bus-reset rules.
module tb_usb_pad_bridge;

    localparam int NP   = 2;
    localparam int SS   = 2;
    localparam int FL   = 3;
    localparam int GC   = 4;
    localparam int SE0  = 250;
    localparam int MAXE = 4096;

    logic            clk;
    logic            rstN;
    logic [NP-1:0]   coreDpO, coreDmO, coreOe;
    logic [NP-1:0]   coreDpI, coreDmI;
    logic [NP-1:0]   padDpO, padDmO, padOe;
    logic [NP-1:0]   padDpI, padDmI;
    logic [2*NP-1:0] lineState;
    logic [NP-1:0]   busReset;

    usb_pad_bridge #(
        .NUM_PORTS(NP), .SYNC_STAGES(SS), .FILT_LEN(FL),
        .GUARD_CYCLES(GC), .SE0_RESET_CYCLES(SE0)
    ) dut (
        .clk(clk), .rst_n(rstN),
        .core_dp_o(coreDpO), .core_dm_o(coreDmO), .core_oe(coreOe),
        .core_dp_i(coreDpI), .core_dm_i(coreDmI),
        .pad_dp_o(padDpO), .pad_dm_o(padDmO), .pad_oe(padOe),
        .pad_dp_i(padDpI), .pad_dm_i(padDmI),
        .line_state(lineState), .bus_reset(busReset)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checksRun;
    int checksPassed;

    // Per-edge history since the last reset; index 0 is the reset state.
    logic [1:0] padH  [NP][MAXE];
    logic       oeH   [NP][MAXE];
    logic [1:0] drvH  [NP][MAXE];
    logic [1:0] sH    [NP][MAXE];
    logic [1:0] fH    [NP][MAXE];
    logic       echoH [NP][MAXE];
    logic [1:0] expCore [NP];
    logic       expBus  [NP];
    int         lastAccept [NP];
    int         lastBad    [NP];
    int         edgeIdx;

    int         holdLeft [NP];
    logic [1:0] padVal   [NP];
    bit         longSe0  [NP];
    int         txLeft   [NP];

    task automatic checkOutput(input string tag, input logic [7:0] observed,
                               input logic [7:0] expected);
        checksRun++;
        if (observed === expected) checksPassed++;
        else $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    endtask

    task automatic resetModel();
        edgeIdx = 0;
        for (int p = 0; p < NP; p++) begin
            fH[p][0]      = 2'b00;
            echoH[p][0]   = 1'b0;
            oeH[p][0]     = 1'b0;
            drvH[p][0]    = 2'b00;
            padH[p][0]    = 2'b00;
            sH[p][0]      = 2'b00;
            lastAccept[p] = 0;
            lastBad[p]    = -1;
        end
    endtask

    // mode 0: free random; mode 1: port 1 held idle SE0; mode 2: as 1 plus port 0 transmitting.
    task automatic applyStimulus(input int mode);
        logic [1:0] pv;
        logic [1:0] dv;
        logic       oe;
        for (int p = 0; p < NP; p++) begin
            if (holdLeft[p] == 0) begin
                if ($urandom_range(0, 99) < 12) begin
                    padVal[p]   = 2'b00;
                    holdLeft[p] = $urandom_range(260, 320);
                    longSe0[p]  = 1'b1;
                end else begin
                    padVal[p]   = 2'($urandom_range(0, 3));
                    holdLeft[p] = $urandom_range(1, 8);
                    longSe0[p]  = 1'b0;
                end
            end
            holdLeft[p]--;
            if (txLeft[p] == 0 && $urandom_range(0, longSe0[p] ? 599 : 59) == 0)
                txLeft[p] = $urandom_range(2, 12);
            oe = (txLeft[p] > 0);
            if (txLeft[p] > 0) txLeft[p]--;
            pv = padVal[p];
            dv = 2'($urandom_range(0, 3));
            if (mode >= 1 && p == 1) begin
                pv = 2'b00;
                oe = 1'b0;
            end
            if (mode == 2 && p == 0) oe = 1'b1;
            padDpI[p]  = pv[1];
            padDmI[p]  = pv[0];
            coreOe[p]  = oe;
            coreDpO[p] = dv[1];
            coreDmO[p] = dv[0];
            padH[p][edgeIdx+1] = pv;
            oeH[p][edgeIdx+1]  = oe;
            drvH[p][edgeIdx+1] = dv;
        end
    endtask

    task automatic modelStep();
        int  e;
        bit  allDiff;
        edgeIdx++;
        e = edgeIdx;
        for (int p = 0; p < NP; p++) begin
            sH[p][e] = (e - SS >= 1) ? padH[p][e-SS] : 2'b00;
            fH[p][e] = fH[p][e-1];
            if (e - FL + 1 > lastAccept[p]) begin
                allDiff = 1'b1;
                for (int k = 0; k < FL; k++)
                    if (sH[p][e-k] == fH[p][e-1]) allDiff = 1'b0;
                if (allDiff) begin
                    fH[p][e]      = sH[p][e];
                    lastAccept[p] = e;
                end
            end
            echoH[p][e] = 1'b0;
            for (int j = e - GC; j <= e; j++)
                if (j >= 1 && oeH[p][j]) echoH[p][e] = 1'b1;
            if (fH[p][e-1] != 2'b00 || echoH[p][e-1]) lastBad[p] = e - 1;
            expBus[p]  = ((e - 1 - lastBad[p]) >= SE0);
            expCore[p] = echoH[p][e] ? drvH[p][e] : fH[p][e];
        end
    endtask

    task automatic runCycles(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            applyStimulus(mode);
            @(posedge clk);
            modelStep();
            #1;
            for (int p = 0; p < NP; p++) begin
                checkOutput($sformatf("drive%0d", p), {padOe[p], padDpO[p], padDmO[p]},
                            {oeH[p][edgeIdx], drvH[p][edgeIdx]});
                checkOutput($sformatf("lineState%0d", p), lineState[2*p +: 2], fH[p][edgeIdx]);
                checkOutput($sformatf("coreIn%0d", p), {coreDpI[p], coreDmI[p]}, expCore[p]);
                checkOutput($sformatf("busReset%0d", p), busReset[p], expBus[p]);
            end
        end
    endtask

    task automatic checkCleared(input string when);
        for (int p = 0; p < NP; p++) begin
            checkOutput($sformatf("%sPadOe%0d", when, p), padOe[p], 1'b0);
            checkOutput($sformatf("%sBusReset%0d", when, p), busReset[p], 1'b0);
            checkOutput($sformatf("%sCoreIn%0d", when, p), {coreDpI[p], coreDmI[p]}, 2'b00);
            checkOutput($sformatf("%sLineState%0d", when, p), lineState[2*p +: 2], 2'b00);
        end
    endtask

    initial begin
        checksRun    = 0;
        checksPassed = 0;
        rstN    = 1'b0;
        coreDpO = '0;
        coreDmO = '0;
        coreOe  = '0;
        padDpI  = '0;
        padDmI  = '0;
        for (int p = 0; p < NP; p++) begin
            holdLeft[p] = 0;
            padVal[p]   = 2'b00;
            longSe0[p]  = 1'b0;
            txLeft[p]   = 0;
        end
        #12;
        checkCleared("reset");
        rstN = 1'b1;
        resetModel();

        runCycles(1500, 0);
        runCycles(300, 1);
        runCycles(5, 2);

        // Pull reset between edges while port 0 drives and port 1 sits in bus reset.
        #3 rstN = 1'b0;
        #2 checkCleared("midReset");
        #2 rstN = 1'b1;
        resetModel();

        runCycles(1500, 0);

        $display("%0d/%0d checks passed", checksPassed, checksRun);
        $finish;
    end

endmodule
